bpu_ctrl_hazard: RTL
====================

Name: bpu_ctrl_hazard

Overview:
- Parametrised control-hazard unit for the pipelined RV32I core. Adds branch prediction to the fetch path: a direct-mapped BTB with N-bit saturating counters.
- Tracks each fetched instruction's prediction through a shadow pipeline to the resolve stage.
- At the resolve stage, detects mispredicts, generates redirect and flush, trains the table, and keeps statistics counters.
- Fetch uses the prediction in the same cycle. Branches resolve in the stage given by RES_STAGE.

Parameters:
- ADDR_W, 10: word-address width of instruction memory (iaddr).
- ENTRIES, 16: BTB entries; power of 2, ≥2. IDX_W = log2(ENTRIES).
- CTR_W, 2: saturating-counter width, ≥1.
- RES_STAGE, 3: pipeline registers between IF and the resolve stage; ≥2. 3 means sh0=ID, sh1=EX, sh2=MEM.
- STAT_W, 16: statistics counter width.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- f_valid  in  1  fetch of f_pc occurs this cycle.
- f_pc  in  ADDR_W  current fetch word address.
- stall  in  1  load-use hazard: PC and IF/ID hold, bubble into EX.
- p_taken  out  1  predicted taken for f_pc (combinational).
- p_target  out  ADDR_W  predicted next fetch address (combinational).
- r_is_branch  in  1  instruction in resolve stage is a branch/jump.
- r_taken  in  1  actual outcome.
- r_target  in  ADDR_W  actual taken target.
- mispredict  out  1  resolve-stage mispredict (combinational).
- redirect_pc  out  ADDR_W  correct next address; valid when mispredict=1.
- flush  out  1  equals mispredict; squashes IF..resolve-1.
- branch_cnt  out  STAT_W  resolved branches, saturating.
- mispred_cnt  out  STAT_W  mispredicts, saturating.

Behaviour:
- Reset (async, immediate):
  - All BTB entries invalid; counters = 2^(CTR_W-1)-1 (weakly not-taken).
  - All shadow stages invalid.
  - branch_cnt = mispred_cnt = 0.
  - Outputs are therefore p_taken=0, p_target=f_pc+1, mispredict=flush=0, redirect_pc=0.
  - Reset mid-operation discards in-flight state; no update occurs on that edge.
- Entry layout: {valid, tag = pc[ADDR_W-1:IDX_W], ctr, target}. Index = pc[IDX_W-1:0].
- Lookup (combinational, registered table):
  - hit = valid && tag match.
  - p_taken = hit && ctr MSB.
  - p_target = p_taken ? target : f_pc+1, with wrap mod 2^ADDR_W.
- Shadow pipeline: sh[0..RES_STAGE-1], each holding {v, pc, pt, ptgt}. Head = sh[RES_STAGE-1]. Per edge, priority order:
  - flush: all sh invalidated. The fetch in the current cycle is not captured (wrong path).
  - stall: sh[0] holds, sh[1].v <= 0, sh[k] <= sh[k-1] for k ≥ 2.
  - otherwise: sh[0] <= {f_valid, f_pc, p_taken, p_target}; sh[k] <= sh[k-1].
- Resolve (head.v=1):
  - actual = r_is_branch && r_taken ? r_target : head.pc+1.
  - mispredict = (actual != (head.pt ? head.ptgt : head.pc+1)).
  - A non-branch with pt=1 (alias) is a mispredict.
  - redirect_pc = actual.
  - head.v=0 → mispredict=0; r_* ignored.
- Update at edge (head.v=1), applied to entry at head.pc index:
  - Branch, taken: ctr++ (saturate at max). Write valid=1, tag, target=r_target. Replaces on tag mismatch; a new entry gets ctr = 2^(CTR_W-1) (weakly taken).
  - Branch, not taken: on hit, ctr-- (saturate at 0). On miss, no allocation.
  - Non-branch that hits: entry invalidated.
  - branch_cnt++ if r_is_branch. mispred_cnt++ if mispredict. Both saturate at 2^STAT_W-1.
- Same-cycle lookup and update on the same index: lookup returns the pre-update value.
- stall and mispredict in the same cycle: flush wins; the stall has no effect on shadow state.

Test Plan:
- Reset, f_pc=0x010 → p_taken=0, p_target=0x011. Reset asserted mid-run → counters 0, no mispredict on the following cycles.
- Loop: branch at 0x020 → 0x018, taken, resolved 3× (RES_STAGE=3):
  - 1st resolve: mispredict=1, redirect=0x018.
  - Entry allocates ctr=10; 2nd fetch predicts taken, p_target=0x018, no mispredict; ctr saturates at 11.
  - Final not-taken: mispredict=1, redirect=0x021.
- Flush: mispredict while sh0/sh1 valid → next cycle both invalid. Fetch in the flush cycle is not captured; no spurious resolve 1–2 cycles later.
- Stall: stall=1 for one cycle with an instruction in sh0 → bubble in sh1. The instruction reaches head one cycle later, and head.pc matches the stalled instruction.
- Alias: 0x004 and 0x014 share an index (ENTRIES=16).
  - Train 0x004 taken; fetch 0x014 → p_taken=0 (tag miss).
  - Force a same-tag non-branch hit → mispredict=1, redirect=pc+1, entry invalidated.
- Saturation: STAT_W=4, 20 mispredicts → mispred_cnt=15. f_pc=0x3FF not taken → p_target=0x000 (wrap).

Source files
------------

// File: rtl/bpu_ctrl_hazard.sv
// Control-hazard unit: direct-mapped BTB with saturating counters feeding the
// fetch stage, a shadow pipeline carrying each fetch's prediction to the
// resolve stage, mispredict/redirect/flush generation, table training and
// saturating statistics.
module bpu_ctrl_hazard #(
  parameter int ADDR_W    = 10,
  parameter int ENTRIES   = 16,
  parameter int CTR_W     = 2,
  parameter int RES_STAGE = 3,
  parameter int STAT_W    = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              f_valid,
  input  logic [ADDR_W-1:0] f_pc,
  input  logic              stall,
  output logic              p_taken,
  output logic [ADDR_W-1:0] p_target,
  input  logic              r_is_branch,
  input  logic              r_taken,
  input  logic [ADDR_W-1:0] r_target,
  output logic              mispredict,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              flush,
  output logic [STAT_W-1:0] branch_cnt,
  output logic [STAT_W-1:0] mispred_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W;
  localparam int HEAD  = RES_STAGE - 1;

  // Weakly not-taken is the reset value; weakly taken is used on allocation.
  localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'((1 << (CTR_W - 1)) - 1);
  localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1 << (CTR_W - 1));
  localparam logic [CTR_W-1:0] CTR_MAX = '1;
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  // Branch target buffer, one row per index.
  logic              btb_v   [ENTRIES];
  logic [TAG_W-1:0]  btb_tag [ENTRIES];
  logic [CTR_W-1:0]  btb_ctr [ENTRIES];
  logic [ADDR_W-1:0] btb_tgt [ENTRIES];

  // Shadow pipeline; index HEAD is the instruction in the resolve stage.
  logic              sh_v    [RES_STAGE];
  logic [ADDR_W-1:0] sh_pc   [RES_STAGE];
  logic              sh_pt   [RES_STAGE];
  logic [ADDR_W-1:0] sh_ptgt [RES_STAGE];

  logic [IDX_W-1:0]  f_idx;
  logic [TAG_W-1:0]  f_tag;
  logic              f_hit;
  logic [IDX_W-1:0]  r_idx;
  logic [TAG_W-1:0]  r_tag;
  logic              r_hit;
  logic [ADDR_W-1:0] head_seq;
  logic [ADDR_W-1:0] actual_next;
  logic [ADDR_W-1:0] pred_next;

  assign f_idx = f_pc[IDX_W-1:0];
  assign f_tag = f_pc[ADDR_W-1:IDX_W];
  assign r_idx = sh_pc[HEAD][IDX_W-1:0];
  assign r_tag = sh_pc[HEAD][ADDR_W-1:IDX_W];
  assign r_hit = btb_v[r_idx] && (btb_tag[r_idx] == r_tag);

  // Fetch-side lookup reads the registered table, so a same-cycle update is not visible yet.
  always_comb begin
    f_hit    = btb_v[f_idx] && (btb_tag[f_idx] == f_tag);
    p_taken  = f_hit && btb_ctr[f_idx][CTR_W-1];
    p_target = p_taken ? btb_tgt[f_idx] : f_pc + ADDR_W'(1);
  end

  // Resolve: compare the real next address against what fetch assumed for the head.
  always_comb begin
    head_seq    = sh_pc[HEAD] + ADDR_W'(1);
    actual_next = (r_is_branch && r_taken) ? r_target : head_seq;
    pred_next   = sh_pt[HEAD] ? sh_ptgt[HEAD] : head_seq;
    mispredict  = sh_v[HEAD] && (actual_next != pred_next);
    flush       = mispredict;
    redirect_pc = mispredict ? actual_next : '0;
  end

  // Shadow pipeline advance: flush beats stall, stall holds sh0 and drops a bubble into sh1.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int k = 0; k < RES_STAGE; k++) begin
        sh_v[k]    <= 1'b0;
        sh_pc[k]   <= '0;
        sh_pt[k]   <= 1'b0;
        sh_ptgt[k] <= '0;
      end
    end else if (mispredict) begin
      for (int k = 0; k < RES_STAGE; k++) begin
        sh_v[k] <= 1'b0;
      end
    end else begin
      if (!stall) begin
        sh_v[0]    <= f_valid;
        sh_pc[0]   <= f_pc;
        sh_pt[0]   <= p_taken;
        sh_ptgt[0] <= p_target;
      end
      for (int k = 1; k < RES_STAGE; k++) begin
        sh_v[k]    <= (stall && (k == 1)) ? 1'b0 : sh_v[k-1];
        sh_pc[k]   <= sh_pc[k-1];
        sh_pt[k]   <= sh_pt[k-1];
        sh_ptgt[k] <= sh_ptgt[k-1];
      end
    end
  end

  // Train the entry indexed by the resolving instruction's pc.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_v[i]   <= 1'b0;
        btb_tag[i] <= '0;
        btb_ctr[i] <= CTR_WNT;
        btb_tgt[i] <= '0;
      end
    end else if (sh_v[HEAD]) begin
      if (r_is_branch && r_taken) begin
        btb_v[r_idx]   <= 1'b1;
        btb_tag[r_idx] <= r_tag;
        btb_tgt[r_idx] <= r_target;
        if (!r_hit) begin
          btb_ctr[r_idx] <= CTR_WT;
        end else if (btb_ctr[r_idx] != CTR_MAX) begin
          btb_ctr[r_idx] <= btb_ctr[r_idx] + CTR_W'(1);
        end
      end else if (r_is_branch) begin
        if (r_hit && (btb_ctr[r_idx] != '0)) begin
          btb_ctr[r_idx] <= btb_ctr[r_idx] - CTR_W'(1);
        end
      end else if (r_hit) begin
        btb_v[r_idx] <= 1'b0;
      end
    end
  end

  // Saturating statistics for resolved branches and mispredicts.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else if (sh_v[HEAD]) begin
      if (r_is_branch && (branch_cnt != STAT_MAX)) begin
        branch_cnt <= branch_cnt + STAT_W'(1);
      end
      if (mispredict && (mispred_cnt != STAT_MAX)) begin
        mispred_cnt <= mispred_cnt + STAT_W'(1);
      end
    end
  end

endmodule
